// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
// Requests are level-held by the master until the one-cycle MEM_valid_o pulse.
interface dmem_responder_if #(
    parameter int BITSIZE = 32
);
    logic [BITSIZE-1:0] MEM_addr_i;
    logic [BITSIZE-1:0] MEM_data_i;
    logic               MEM_read_i;
    logic               MEM_write_i;
    logic [1:0]         MEM_write_size_i;
    logic [BITSIZE-1:0] MEM_data_o;
    logic               MEM_valid_o;
    logic               MEM_err_o;

    modport master (
        output MEM_addr_i, MEM_data_i, MEM_read_i, MEM_write_i, MEM_write_size_i,
        input  MEM_data_o, MEM_valid_o, MEM_err_o
    );

    modport slave (
        input  MEM_addr_i, MEM_data_i, MEM_read_i, MEM_write_i, MEM_write_size_i,
        output MEM_data_o, MEM_valid_o, MEM_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised little-endian RAM behind a fixed-latency
// level-held request bus, with byte/half/word lanes and misalign/range error reporting.
module dmem_responder #(
    parameter int BITSIZE     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset_i,
    dmem_responder_if.slave mem
);

    localparam int                 IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [BITSIZE-3:0] DEPTH_L = (BITSIZE-2)'(DEPTH_WORDS);
    localparam logic [3:0]         LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic [BITSIZE-1:0] wdata_q, wdata_d;
    logic [BITSIZE-1:0] rdata_q, rdata_d;
    logic [1:0]         size_q, size_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;

    logic [BITSIZE-1:0] mem_q [DEPTH_WORDS];

    logic [BITSIZE-3:0] word_idx;
    logic [1:0]         offset;
    logic [IDX_W-1:0]   ram_idx;
    logic               req_err;
    logic [BITSIZE-1:0] ram_word;
    logic [BITSIZE-1:0] shifted;
    logic [BITSIZE-1:0] load_mask;
    logic [BITSIZE-1:0] load_result;
    logic [BITSIZE-1:0] wr_aligned;
    logic [3:0]         byte_en;
    logic               commit;

    // Everything below works only from the request captured at acceptance.
    always_comb begin
        word_idx = addr_q[BITSIZE-1:2];
        offset   = addr_q[1:0];
        ram_idx  = word_idx[IDX_W-1:0];

        req_err = (size_q == 2'b11)
                | ((size_q == 2'b01) && offset[0])
                | ((size_q == 2'b10) && (offset != 2'b00))
                | (word_idx >= DEPTH_L)
                | (rd_q && wr_q);

        ram_word = mem_q[ram_idx];
        shifted  = ram_word >> {offset, 3'b000};

        case (size_q)
            2'b00:   load_mask = BITSIZE'(8'hFF);
            2'b01:   load_mask = BITSIZE'(16'hFFFF);
            default: load_mask = '1;
        endcase

        // Stores and failed accesses return zero data.
        load_result = (rd_q && !req_err) ? (shifted & load_mask) : '0;

        case (size_q)
            2'b00:   byte_en = 4'b0001 << offset;
            2'b01:   byte_en = 4'b0011 << offset;
            default: byte_en = 4'b1111;
        endcase

        wr_aligned = wdata_q << {offset, 3'b000};
        commit     = (state_q == RESP) && wr_q && !req_err;
    end

    always_ff @(posedge clk) begin
        if (commit && !reset_i) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[ram_idx][8*b +: 8] <= wr_aligned[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (mem.MEM_read_i || mem.MEM_write_i) begin
                    addr_d  = mem.MEM_addr_i;
                    wdata_d = mem.MEM_data_i;
                    size_d  = mem.MEM_write_size_i;
                    rd_d    = mem.MEM_read_i;
                    wr_d    = mem.MEM_write_i;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata_d = load_result;
                state_d = GAP;
            end
            // GAP keeps a request still held during RESP from being served twice.
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Data is live during the pulse and then held from rdata_q.
    assign mem.MEM_valid_o = (state_q == RESP);
    assign mem.MEM_err_o   = (state_q == RESP) && req_err;
    assign mem.MEM_data_o  = (state_q == RESP) ? load_result : rdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store memory interface; it sits on the far side of the MEM pipeline stage.
- Accepts level-held read/write requests (addr, write data, size), waits a programmable latency, then returns read data and a one-cycle valid pulse.
- Backs a word-organised little-endian RAM with byte/halfword/word lane handling and error signalling for misaligned or out-of-range accesses.

Parameters:
- BITSIZE, 32, data/address width (only 32 supported).
- DEPTH_WORDS, 1024, number of 32-bit words in the array; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, cycles from request acceptance to MEM_valid_o (legal range 1..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- MEM_addr_i  input  BITSIZE  byte address of the access.
- MEM_data_i  input  BITSIZE  store data, right-aligned (byte in [7:0], half in [15:0]).
- MEM_read_i  input  1  load request, held by the initiator until valid.
- MEM_write_i  input  1  store request, held by the initiator until valid.
- MEM_write_size_i  input  2  access size for loads and stores: 00 byte, 01 half, 10 word, 11 illegal.
- MEM_data_o  output  BITSIZE  load data, right-aligned, upper bits zero (the initiator extends).
- MEM_valid_o  output  1  one-cycle completion pulse.
- MEM_err_o  output  1  one-cycle error flag, coincident with MEM_valid_o.

Behaviour:
- Reset: MEM_valid_o=0, MEM_err_o=0, MEM_data_o=0, state IDLE, latency counter 0. Array contents are not cleared; reset mid-operation aborts the access with no write commit and no valid.
- States:
  - IDLE: when MEM_read_i or MEM_write_i is high, register addr, data, size and op. Go to RESP if LATENCY==1, else go to BUSY with counter=LATENCY-1.
  - BUSY: decrement the counter each cycle. Request inputs are ignored. Go to RESP when the counter reaches 1.
  - RESP: MEM_valid_o=1 for exactly this cycle. The store commit happens on this edge. Next state is GAP.
  - GAP: one cycle with valid low and inputs ignored, so a request still held in the valid cycle is not served twice. Next state is IDLE.
- Latency: request high in IDLE at cycle t gives MEM_valid_o high at cycle t+LATENCY. Back-to-back throughput is one access per LATENCY+2 cycles.
- Only values registered at acceptance are used; input changes during BUSY have no effect.
- Lane mapping: word index = addr[BITSIZE-1:2]; byte offset = addr[1:0]; little-endian (offset 0 is bits [7:0]).
- Store byte: write lane offset with data[7:0]. Store half: write lanes offset and offset+1 with data[15:0]. Store word: write the whole word. All other lanes are unchanged.
- Load: the word is shifted right by 8*offset, then masked to 8, 16 or 32 bits by size. MEM_data_o updates in RESP and holds until the next RESP or reset.
- Error conditions (checked on the registered request):
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= DEPTH_WORDS;
  - read and write both high at acceptance.
- On error: still go through BUSY/RESP with the normal latency. MEM_err_o=1 with valid, no array write, MEM_data_o=0.
- Read-after-write: a load accepted after a store's RESP sees the committed data.

Test Plan:
- Reset then idle, no requests for 10 cycles -> valid, err and data_o stay 0. Reset asserted during BUSY of a store -> no valid; a later load shows the old data.
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 (LATENCY=2) -> each valid exactly 2 cycles after the request, one-cycle pulse; data_o=0xDEADBEEF.
- After the previous store: store half 0x1234 to 0x12, store byte 0xAA to 0x10, then load word 0x10 -> 0x1234BEAA. Load byte 0x11 -> 0x000000BE. Load half 0x12 -> 0x00001234.
- Request held high for 3 cycles after valid -> only one valid pulse; the access is re-served only if the request is still high in IDLE after GAP.
- Load half from 0x13, load word from 0x12, size 11, word at byte address 4*DEPTH_WORDS, read+write together -> each gives valid=1, err=1, data_o=0; target words unchanged on readback.
- LATENCY=1 build: load word -> valid in the cycle after the request; back-to-back requests are spaced 3 cycles apart.
